// File: rtl/master_spi_shift_datapath.sv
// SPI master shift datapath (mode 0). It generates SCLK, CS_n and MOSI, captures MISO, and flags the end of a word to the FSM.
// Define MASTER_SPI_LSB_FIRST_EN to shift LSB first. By default the word is shifted MSB first.

module master_spi_shift_datapath_checker (
  input logic clk_c,
  input logic reset_r,
  input logic sclk,
  input logic cs_n,
  input logic mosi,
  input logic transmittedAllBitsFlag
);

  property pSclkLowWhenDeselected;
    @(posedge clk_c) disable iff (!reset_r) cs_n |-> !sclk;
  endproperty

  property pMosiLowWhenDeselected;
    @(posedge clk_c) disable iff (!reset_r) cs_n |-> !mosi;
  endproperty

  property pFlagSingleCycle;
    @(posedge clk_c) disable iff (!reset_r) transmittedAllBitsFlag |=> !transmittedAllBitsFlag;
  endproperty

  aSclkLowWhenDeselected: assert property (pSclkLowWhenDeselected);
  aMosiLowWhenDeselected: assert property (pMosiLowWhenDeselected);
  aFlagSingleCycle:       assert property (pFlagSingleCycle);

endmodule

module master_spi_shift_datapath #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk_c,
  input  logic                  reset_r,
  input  logic                  writeInputDataFlag,
  input  logic                  peripheralEN,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic                  transmittedAllBitsFlag
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   txShift;
  logic [DATA_WIDTH-1:0]   rxShift;
  logic [DIV_W-1:0]        divCnt;
  logic [CNT_W-1:0]        bitCnt;
  logic [DATA_WIDTH-1:0]   txShifted;
  logic [DATA_WIDTH-1:0]   rxShifted;
  logic                    txBit;

`ifdef MASTER_SPI_LSB_FIRST_EN
  assign txShifted = {1'b0, txShift[DATA_WIDTH-1:1]};
  assign rxShifted = {miso, rxShift[DATA_WIDTH-1:1]};
  assign txBit     = txShift[0];
`else
  assign txShifted = {txShift[DATA_WIDTH-2:0], 1'b0};
  assign rxShifted = {rxShift[DATA_WIDTH-2:0], miso};
  assign txBit     = txShift[DATA_WIDTH-1];
`endif

  // MOSI is held low whenever the slave is deselected.
  assign mosi = cs_n ? 1'b0 : txBit;

  // Transfer sequencing: load, SCLK generation, shifting and the end-of-word pulse.
  always_ff @(posedge clk_c) begin
    if (!reset_r) begin
      state                  <= IDLE;
      sclk                   <= 1'b0;
      cs_n                   <= 1'b1;
      rxData                 <= {DATA_WIDTH{1'b0}};
      transmittedAllBitsFlag <= 1'b0;
      txShift                <= {DATA_WIDTH{1'b0}};
      rxShift                <= {DATA_WIDTH{1'b0}};
      divCnt                 <= {DIV_W{1'b0}};
      bitCnt                 <= {CNT_W{1'b0}};
    end else begin
      transmittedAllBitsFlag <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= 1'b0;
          cs_n <= 1'b1;
          if (peripheralEN) begin
            state  <= SHIFT;
            cs_n   <= 1'b0;
            divCnt <= {DIV_W{1'b0}};
            bitCnt <= {CNT_W{1'b0}};
          end else if (writeInputDataFlag) begin
            txShift <= txData;
          end
        end
        SHIFT: begin
          if (!peripheralEN) begin
            state <= IDLE;
            cs_n  <= 1'b1;
            sclk  <= 1'b0;
          end else if (divCnt == DIV_LAST) begin
            divCnt <= {DIV_W{1'b0}};
            sclk   <= ~sclk;
            if (!sclk) begin
              rxShift <= rxShifted;
            end else begin
              // Falling edge: present the next bit and count the completed one.
              txShift <= txShifted;
              bitCnt  <= bitCnt + CNT_W'(1);
              if (bitCnt == BIT_LAST) begin
                state                  <= DONE;
                rxData                 <= rxShift;
                transmittedAllBitsFlag <= 1'b1;
              end
            end
          end else begin
            divCnt <= divCnt + DIV_W'(1);
          end
        end
        DONE: begin
          sclk <= 1'b0;
          if (!peripheralEN) begin
            state <= IDLE;
            cs_n  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          sclk  <= 1'b0;
          cs_n  <= 1'b1;
        end
      endcase
    end
  end

  master_spi_shift_datapath_checker uChecker (
    .clk_c                  (clk_c),
    .reset_r                (reset_r),
    .sclk                   (sclk),
    .cs_n                   (cs_n),
    .mosi                   (mosi),
    .transmittedAllBitsFlag (transmittedAllBitsFlag)
  );

endmodule

// File: tb/tb_master_spi_shift_datapath.sv
// Bench for master_spi_shift_datapath. A transfer-level model predicts every output cycle by cycle, and directed tests pin literal values.
module tb_master_spi_shift_datapath;

  localparam int DW = 8;
  localparam int CD = 2;
  localparam int TW = 2 * DW * CD;

  logic          clk_c = 1'b0;
  logic          reset_r = 1'b0;
  logic          writeInputDataFlag = 1'b0;
  logic          peripheralEN = 1'b0;
  logic [DW-1:0] txData = 8'h00;
  logic          miso;
  logic          sclk, cs_n, mosi, transmittedAllBitsFlag;
  logic [DW-1:0] rxData;
  logic          loopMode = 1'b0;
  logic          misoConst = 1'b0;

  int nChecks = 0;
  int nFails = 0;

  always #5 clk_c = ~clk_c;

  assign miso = loopMode ? mosi : misoConst;

  master_spi_shift_datapath #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk_c                  (clk_c),
    .reset_r                (reset_r),
    .writeInputDataFlag     (writeInputDataFlag),
    .peripheralEN           (peripheralEN),
    .txData                 (txData),
    .miso                   (miso),
    .sclk                   (sclk),
    .cs_n                   (cs_n),
    .mosi                   (mosi),
    .rxData                 (rxData),
    .transmittedAllBitsFlag (transmittedAllBitsFlag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: a transfer is a window of TW cycles indexed by mK.
  logic          mValid = 1'b0;
  logic          mActive = 1'b0;
  logic          mDone = 1'b0;
  logic          mFlag = 1'b0;
  int            mK = 0;
  logic [DW-1:0] mTx = 8'h00;
  logic [DW-1:0] mWord = 8'h00;
  logic [DW-1:0] mAcc = 8'h00;
  logic [DW-1:0] mRx = 8'h00;

  function automatic logic modelMosi();
    int idx;
    if (!mActive) return 1'b0;
    idx = mK / (2 * CD);
`ifdef MASTER_SPI_LSB_FIRST_EN
    return mWord[idx];
`else
    return mWord[DW-1-idx];
`endif
  endfunction

  always @(posedge clk_c) begin
    logic m;
    int   idx;
    if (!reset_r) begin
      mValid = 1'b1; mActive = 1'b0; mDone = 1'b0; mFlag = 1'b0;
      mK = 0; mTx = 8'h00; mRx = 8'h00;
    end else begin
      mFlag = 1'b0;
      if (mActive) begin
        if (!peripheralEN) begin
          mActive = 1'b0;
        end else begin
          if ((mK + 1) % (2 * CD) == CD) begin
            m   = loopMode ? modelMosi() : misoConst;
            idx = (mK + 1) / (2 * CD);
`ifdef MASTER_SPI_LSB_FIRST_EN
            mAcc[idx] = m;
`else
            mAcc[DW-1-idx] = m;
`endif
          end
          if (mK + 1 == TW) begin
            mActive = 1'b0; mDone = 1'b1; mRx = mAcc; mFlag = 1'b1;
          end else begin
            mK++;
          end
        end
      end else if (mDone) begin
        if (!peripheralEN) mDone = 1'b0;
      end else if (peripheralEN) begin
        mActive = 1'b1; mK = 0; mWord = mTx; mAcc = 8'h00;
      end else if (writeInputDataFlag) begin
        mTx = txData;
      end
    end
  end

  // Observation counters, kept monotonic so that tests take deltas.
  int            cyc = 0, riseCnt = 0, fallCnt = 0, flagCnt = 0, mosiOnes = 0;
  int            csFallCyc = 0, flagDelta = 0, gapRun = 0, lastGap = 0;
  logic          armed = 1'b0, prevSclk = 1'b0, prevCs = 1'b1;
  logic [DW-1:0] samples = 8'h00;

  always @(negedge clk_c) begin
    cyc++;
    if (mValid) begin
      check("cyc_sclk", 32'(sclk), mActive ? 32'((mK / CD) % 2) : 32'd0);
      check("cyc_cs_n", 32'(cs_n), 32'(!(mActive || mDone)));
      check("cyc_mosi", 32'(mosi), 32'(modelMosi()));
      check("cyc_rxData", 32'(rxData), 32'(mRx));
      check("cyc_flag", 32'(transmittedAllBitsFlag), 32'(mFlag));
    end
    if (sclk === 1'b1 && prevSclk === 1'b0) begin
      riseCnt++;
      samples = {samples[DW-2:0], mosi};
    end
    if (sclk === 1'b0 && prevSclk === 1'b1) fallCnt++;
    if (mosi === 1'b1 && cs_n === 1'b0) mosiOnes++;
    if (transmittedAllBitsFlag === 1'b1) begin
      flagCnt++; flagDelta = cyc - csFallCyc; armed = 1'b1; gapRun = 0;
    end
    if (cs_n === 1'b1 && armed) gapRun++;
    if (cs_n === 1'b0 && prevCs === 1'b1) begin
      csFallCyc = cyc;
      if (armed) begin lastGap = gapRun; armed = 1'b0; end
    end
    prevSclk = sclk;
    prevCs = cs_n;
  end

  task automatic tick();
    @(posedge clk_c);
    #1;
  endtask

  task automatic sendWord(input logic [DW-1:0] w);
    logic got;
    txData = w; writeInputDataFlag = 1'b1;
    tick(); tick();
    writeInputDataFlag = 1'b0; peripheralEN = 1'b1;
    tick();
    got = 1'b0;
    for (int i = 0; i < TW + 20 && !got; i++) begin
      @(negedge clk_c);
      if (transmittedAllBitsFlag === 1'b1) got = 1'b1;
    end
    check("flag_seen", 32'(got), 32'd1);
    @(posedge clk_c); #1;
    peripheralEN = 1'b0;
    tick();
  endtask

  initial begin #200000; $display("FAIL watchdog expired"); $fatal(1, "timeout"); end

  initial begin
    int   r0, f0, o0, fl0;
    logic got;

    // Reset state
    reset_r = 1'b0;
    repeat (3) tick();
    @(negedge clk_c);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rxData", 32'(rxData), 32'h00);
    check("rst_flag", 32'(transmittedAllBitsFlag), 32'd0);
    reset_r = 1'b1;
    tick();

    // Loopback 0xA5 (bit pattern is a palindrome, so valid for either order)
    loopMode = 1'b1;
    r0 = riseCnt; fl0 = flagCnt;
    sendWord(8'hA5);
    check("a5_rxData", 32'(rxData), 32'hA5);
    check("a5_mosi_samples", 32'(samples), 32'hA5);
    check("a5_flag_delay", 32'(flagDelta), 32'd32);
    check("a5_rises", 32'(riseCnt - r0), 32'd8);
    check("a5_flags", 32'(flagCnt - fl0), 32'd1);

    // miso tied high, all-zero word
    loopMode = 1'b0; misoConst = 1'b1;
    r0 = riseCnt; o0 = mosiOnes;
    sendWord(8'h00);
    check("ones_rxData", 32'(rxData), 32'hFF);
    check("ones_rises", 32'(riseCnt - r0), 32'd8);
    check("ones_mosi_high", 32'(mosiOnes - o0), 32'd0);

    // Abort after the third falling edge
    misoConst = 1'b0; fl0 = flagCnt; f0 = fallCnt;
    txData = 8'h5A; writeInputDataFlag = 1'b1;
    tick(); tick();
    writeInputDataFlag = 1'b0; peripheralEN = 1'b1;
    got = 1'b0;
    for (int i = 0; i < TW + 20 && !got; i++) begin
      @(negedge clk_c);
      if (fallCnt - f0 >= 3) got = 1'b1;
    end
    check("abort_third_fall", 32'(got), 32'd1);
    @(posedge clk_c); #1;
    peripheralEN = 1'b0;
    tick();
    @(negedge clk_c);
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    repeat (40) tick();
    check("abort_no_flag", 32'(flagCnt - fl0), 32'd0);
    check("abort_rxData", 32'(rxData), 32'hFF);

    // Back-to-back loopback words
    loopMode = 1'b1; r0 = riseCnt; fl0 = flagCnt;
    sendWord(8'hC3);
    check("b2b_rx1", 32'(rxData), 32'hC3);
    sendWord(8'h3C);
    check("b2b_rx2", 32'(rxData), 32'h3C);
    check("b2b_flags", 32'(flagCnt - fl0), 32'd2);
    check("b2b_rises", 32'(riseCnt - r0), 32'd16);
    check("b2b_cs_gap", 32'(lastGap >= 1), 32'd1);

    // Reset in the middle of a transfer
    fl0 = flagCnt;
    txData = 8'h96; writeInputDataFlag = 1'b1;
    tick(); tick();
    writeInputDataFlag = 1'b0; peripheralEN = 1'b1;
    repeat (10) tick();
    reset_r = 1'b0; peripheralEN = 1'b0;
    tick(); tick();
    @(negedge clk_c);
    check("mid_rst_cs_n", 32'(cs_n), 32'd1);
    check("mid_rst_sclk", 32'(sclk), 32'd0);
    check("mid_rst_mosi", 32'(mosi), 32'd0);
    check("mid_rst_rxData", 32'(rxData), 32'h00);
    check("mid_rst_flag", 32'(transmittedAllBitsFlag), 32'd0);
    reset_r = 1'b1;
    repeat (40) tick();
    check("mid_rst_no_flag", 32'(flagCnt - fl0), 32'd0);

`ifdef MASTER_SPI_LSB_FIRST_EN
    // LSB first: only the first transmitted bit is set
    loopMode = 1'b1;
    sendWord(8'h01);
    check("lsb_mosi_samples", 32'(samples), 32'h80);
    check("lsb_rxData", 32'(rxData), 32'h01);
`endif

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
